mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Main controller of the multicycle RV32I datapath. It sits directly upstream of the ALU.
//  Each cycle it drives alu_control and the operand-select lines, and it uses the ALU zero flag to resolve beq.
//  It sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, I-ALU, beq and jal.
//  Fetch and data accesses go through a req/ready handshake so that memory may stall.
// PARAMETERS
//  TRAP_EN  1  1: an illegal opcode/funct parks the FSM in TRAP until reset; 0: return to FETCH (instruction dropped)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  op           in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  zero         in   1  ALU zero flag (result==0)
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request (FETCH/MEMREAD/MEMWRITE)
//  mem_write    out  1  store strobe
//  adr_src      out  1  0: PC, 1: ALUOut as memory address
//  ir_write     out  1  latch instruction and oldPC
//  pc_write     out  1  PC register enable
//  reg_write    out  1  register file write enable
//  result_src   out  2  00 ALUOut, 01 read data, 10 ALU result
//  alu_src_a    out  2  00 PC, 01 oldPC, 10 rs1
//  alu_src_b    out  2  00 rs2, 01 imm, 10 const 4
//  imm_src      out  2  00 I, 01 S, 10 B, 11 J (decoded from op)
//  alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  trap         out  1  high while in TRAP
// BEHAVIOUR
//  State register is the only flop; its async reset value is FETCH. All outputs are combinational from state+instr (+mem_ready, zero).
//  While rst_n=0, every strobe (mem_req, mem_write, ir_write, pc_write, reg_write, trap) is 0.
//  Default outputs are 0 and alu_control=add unless listed below.
//  FETCH: mem_req=1, adr_src=0, a=PC, b=4, add, result_src=10.
//    On mem_ready: ir_write=1, pc_write=1 -> DECODE. Otherwise hold in FETCH with no strobes.
//  DECODE: a=oldPC, b=imm, add (branch target into ALUOut). Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; else ILLEGAL.
//  MEMADR: a=rs1, b=imm, add -> MEMREAD if op[5]=0, otherwise MEMWRITE.
//  MEMREAD: mem_req=1, adr_src=1 -> MEMWB on mem_ready; hold otherwise.
//  MEMWRITE: mem_req=1, mem_write=1, adr_src=1, both held stable until mem_ready -> FETCH.
//  MEMWB: result_src=01, reg_write=1 -> FETCH.
//  EXECR: a=rs1, b=rs2, funct-decoded alu_control -> ALUWB.
//  EXECI: a=rs1, b=imm, funct-decoded alu_control -> ALUWB.
//  ALUWB: result_src=00, reg_write=1 -> FETCH.
//  BEQ: a=rs1, b=rs2, sub, result_src=00, pc_write=zero -> FETCH.
//  JAL: a=oldPC, b=4, add, result_src=00, pc_write=1 -> ALUWB (rd=PC+4).
//  Funct decode (EXECR/EXECI): funct3 000 -> add, except EXECR with funct7b5=1 -> sub.
//    010 -> slt; 110 -> or; 111 -> and. Any other funct3 -> ILLEGAL (no reg_write issued).
//  ILLEGAL: if TRAP_EN=1 -> TRAP; otherwise -> FETCH. TRAP: trap=1, all strobes 0, self-loop until reset.
//  mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE. Reset mid-access drops the access; next cycle is FETCH.
//  Every state other than FETCH/MEMREAD/MEMWRITE/TRAP lasts exactly 1 cycle.
//  With mem_ready tied high: lw=5, sw=4, R/I=4, beq=3, jal=4 cycles.
//  imm_src is a pure function of op; illegal op -> 00.
// STRUCTURE
//  riscv_pkg: state_t enum, opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL).
//    It also holds alu_control codes ALU_ADD/SUB/AND/OR/SLT, shared with the ALU.
//  Sub-module alu_decoder (combinational): alu_op[1:0] + funct3 + funct7b5 + op[5] -> alu_control, illegal.
//  Top level: state register, next-state logic, output decode.
// TESTING
//  1. Reset with mem_ready=1, then op=0110011, f3=000, f7b5=1 -> FETCH, DECODE, EXECR (alu_control=001), ALUWB (reg_write=1), FETCH.
//  2. lw (op=0000011), mem_ready held low 3 cycles in MEMREAD -> mem_req/adr_src stay 1, no reg_write, MEMWB fires after ready.
//  3. beq with zero=1 -> pc_write=1 in BEQ, alu_control=001. Repeat with zero=0 -> pc_write=0. Both return to FETCH.
//  4. op=0010011, f3=110 -> alu_control=011, b=imm. Then op=0010011, f3=001 with TRAP_EN=1 -> trap=1 and the FSM stays stuck until reset.
//  5. sw with mem_ready low 2 cycles -> mem_write held 1 throughout. Then assert rst_n=0 mid-MEMWRITE -> all strobes drop at once; FETCH after release.
//  6. jal -> JAL asserts pc_write, a=01, b=10; ALUWB asserts reg_write; imm_src=11 throughout.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// Module  : riscv_pkg
// Brief   : Shared types and encodings for the multicycle RV32I controller/ALU.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWRITE = 4'd4,
      S_MEMWB    = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Coarse ALU request from the FSM; FUNCT defers to funct3/funct7b5.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;

   localparam logic [1:0] SRC_B_RS2   = 2'b00;
   localparam logic [1:0] SRC_B_IMM   = 2'b01;
   localparam logic [1:0] SRC_B_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_RDATA   = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      logic [1:0] imm;
      case (op)
         OP_SW:   imm = IMM_S;
         OP_BEQ:  imm = IMM_B;
         OP_JAL:  imm = IMM_J;
         default: imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// Module  : alu_decoder
// Brief   : Maps the FSM's coarse ALU request plus funct fields to alu_control.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module alu_decoder
   import riscv_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control,
   output logic       illegal
);

   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only selects sub for register-register ops; addi ignores it.
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: illegal     = 1'b1;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// Module  : mc_control_fsm
// Brief   : Multicycle RV32I main controller with stallable memory handshake.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mc_control_fsm
   import riscv_pkg::*;
#(
   parameter bit TRAP_EN = 1'b1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       trap
);

   state_t     r_state;
   state_t     w_next_state;
   logic [1:0] w_alu_op;
   logic       w_funct_illegal;
   logic       w_mem_req;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_reg_write;
   logic       w_trap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   alu_decoder u_alu_decoder (
      .alu_op      (w_alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control),
      .illegal     (w_funct_illegal)
   );

   always_comb begin
      w_next_state = r_state;
      w_mem_req    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_trap       = 1'b0;
      adr_src      = 1'b0;
      result_src   = RES_ALUOUT;
      alu_src_a    = SRC_A_PC;
      alu_src_b    = SRC_B_RS2;
      w_alu_op     = ALUOP_ADD;

      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU;
            if (mem_ready) begin
               w_ir_write   = 1'b1;
               w_pc_write   = 1'b1;
               w_next_state = S_DECODE;
            end
         end

         S_DECODE: begin
            // Branch target is formed here so BEQ can take it from ALUOut.
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            case (op)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_R:         w_next_state = S_EXECR;
               OP_I:         w_next_state = S_EXECI;
               OP_BEQ:       w_next_state = S_BEQ;
               OP_JAL:       w_next_state = S_JAL;
               default:      w_next_state = S_ILLEGAL;
            endcase
         end

         S_MEMADR: begin
            alu_src_a    = SRC_A_RS1;
            alu_src_b    = SRC_B_IMM;
            w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            w_mem_req = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) begin
               w_next_state = S_MEMWB;
            end
         end

         S_MEMWRITE: begin
            w_mem_req   = 1'b1;
            w_mem_write = 1'b1;
            adr_src     = 1'b1;
            if (mem_ready) begin
               w_next_state = S_FETCH;
            end
         end

         S_MEMWB: begin
            result_src   = RES_RDATA;
            w_reg_write  = 1'b1;
            w_next_state = S_FETCH;
         end

         S_EXECR: begin
            alu_src_a    = SRC_A_RS1;
            alu_src_b    = SRC_B_RS2;
            w_alu_op     = ALUOP_FUNCT;
            w_next_state = w_funct_illegal ? S_ILLEGAL : S_ALUWB;
         end

         S_EXECI: begin
            alu_src_a    = SRC_A_RS1;
            alu_src_b    = SRC_B_IMM;
            w_alu_op     = ALUOP_FUNCT;
            w_next_state = w_funct_illegal ? S_ILLEGAL : S_ALUWB;
         end

         S_ALUWB: begin
            result_src   = RES_ALUOUT;
            w_reg_write  = 1'b1;
            w_next_state = S_FETCH;
         end

         S_BEQ: begin
            alu_src_a    = SRC_A_RS1;
            alu_src_b    = SRC_B_RS2;
            w_alu_op     = ALUOP_SUB;
            result_src   = RES_ALUOUT;
            w_pc_write   = zero;
            w_next_state = S_FETCH;
         end

         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms the link value.
            alu_src_a    = SRC_A_OLDPC;
            alu_src_b    = SRC_B_FOUR;
            result_src   = RES_ALUOUT;
            w_pc_write   = 1'b1;
            w_next_state = S_ALUWB;
         end

         S_ILLEGAL: begin
            w_next_state = TRAP_EN ? S_TRAP : S_FETCH;
         end

         S_TRAP: begin
            w_trap       = 1'b1;
            w_next_state = S_TRAP;
         end

         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // The state flop resets to FETCH, so strobes are also masked while reset is held.
   assign mem_req   = w_mem_req   & rst_n;
   assign mem_write = w_mem_write & rst_n;
   assign ir_write  = w_ir_write  & rst_n;
   assign pc_write  = w_pc_write  & rst_n;
   assign reg_write = w_reg_write & rst_n;
   assign trap      = w_trap      & rst_n;

   assign imm_src   = imm_src_of(op);

endmodule

`default_nettype wire
